// File: rtl/rv32im_pkg.sv
// Shared definitions for the rv32im M-extension divider.
package rv32im_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divider request/response bundle between the pipeline and div_unit.
interface div_unit_if;
    import rv32im_pkg::*;

    logic            StartE;
    div_op_t         DivOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            KillE;
    logic            DivStallE;
    logic            DivDoneE;
    logic [XLEN-1:0] DivResultE;

    modport master (
        output StartE, DivOpE, SrcAE, SrcBE, KillE,
        input  DivStallE, DivDoneE, DivResultE
    );

    modport slave (
        input  StartE, DivOpE, SrcAE, SrcBE, KillE,
        output DivStallE, DivDoneE, DivResultE
    );

endinterface

// File: rtl/div_unit_step.sv
// One restoring division step: shift {rem, quo} left, trial-subtract, keep if non-negative.
module div_unit_step
    import rv32im_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {2'b00, divisor_i};
        if (!diff[XLEN+1]) begin
            rem_o = diff[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU; stalls the pipeline while iterating.
// state | meaning
// IDLE  | waiting for a divide-class instruction in EX
// CALC  | one restoring step per cycle, XLEN steps
// DONE  | result registered, DivDoneE high for one cycle
module div_unit
    import rv32im_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    div_unit_if.slave   div_if
);

    div_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            op_rem_q, op_rem_d;
    logic [XLEN-1:0] res_q, res_d;

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic            signed_op, is_rem, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    div_unit_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        signed_op = (div_if.DivOpE == DIV) || (div_if.DivOpE == REM);
        is_rem    = div_if.DivOpE[1];
        a_neg     = signed_op && div_if.SrcAE[XLEN-1];
        b_neg     = signed_op && div_if.SrcBE[XLEN-1];
        a_mag     = a_neg ? -div_if.SrcAE : div_if.SrcAE;
        b_mag     = b_neg ? -div_if.SrcBE : div_if.SrcBE;
        div_zero  = (div_if.SrcBE == '0);
        ovf       = signed_op && (div_if.SrcAE == OVF_DIVIDEND) && (div_if.SrcBE == '1);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        op_rem_d  = op_rem_q;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                if (div_if.StartE && !div_if.KillE) begin
                    if (div_zero) begin
                        res_d   = is_rem ? div_if.SrcAE : '1;
                        state_d = DONE;
                    end else if (ovf) begin
                        res_d   = is_rem ? '0 : OVF_DIVIDEND;
                        state_d = DONE;
                    end else begin
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        op_rem_d  = is_rem;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1) && !div_if.KillE) begin
                    // Signs are applied once, on the way into DONE
                    if (op_rem_q)
                        res_d = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
                    else
                        res_d = neg_quo_q ? -step_quo : step_quo;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (div_if.KillE)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_rem_q  <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            op_rem_q  <= op_rem_d;
            res_q     <= res_d;
        end
    end

    assign div_if.DivStallE  = !div_if.KillE &&
                               (((state_q == IDLE) && div_if.StartE) || (state_q == CALC));
    assign div_if.DivDoneE   = (state_q == DONE);
    assign div_if.DivResultE = res_q;

endmodule
